// File: rtl/lsu_dmem_ctrl.sv
// Pipelined load/store controller between the core execute stage and data memory.
// Holds one request for issue, tracks in-flight accesses in a tag FIFO and returns completions in order.
module lsu_dmem_ctrl #(
    parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int max_outstanding_p = 4,
    parameter int tag_width_p       = 5
) (
    input  logic                                     clk,
    input  logic                                     n_reset,
    input  logic                                     req_valid_i,
    output logic                                     req_ready_o,
    input  logic                                     req_wen_i,
    input  logic [1:0]                               req_size_i,
    input  logic                                     req_signed_i,
    input  logic [addr_width_p-1:0]                  req_addr_i,
    input  logic [data_width_p-1:0]                  req_wdata_i,
    input  logic [tag_width_p-1:0]                   req_tag_i,
    output logic                                     mem_valid_o,
    output logic                                     mem_wen_o,
    output logic [1:0]                               mem_size_o,
    output logic [addr_width_p-1:0]                  mem_addr_o,
    output logic [data_width_p-1:0]                  mem_wdata_o,
    input  logic                                     mem_yumi_i,
    input  logic                                     mem_rvalid_i,
    input  logic [data_width_p-1:0]                  mem_rdata_i,
    output logic                                     mem_yumi_o,
    output logic                                     rsp_valid_o,
    input  logic                                     rsp_ready_i,
    output logic                                     rsp_is_load_o,
    output logic [tag_width_p-1:0]                   rsp_tag_o,
    output logic [data_width_p-1:0]                  rsp_data_o,
    output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o,
    output logic                                     misalign_o,
    output logic                                     err_o
);

    localparam int nb_lp    = data_width_p / 8;
    localparam int off_w_lp = $clog2(nb_lp);
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
    localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    typedef struct packed {
        logic [tag_width_p-1:0] tag;
        logic [1:0]             size;
        logic                   sgn;
        logic                   wen;
        logic [off_w_lp-1:0]    off;
    } entry_t;

    logic                      pending_q, pending_d;
    logic                      wen_q, wen_d;
    logic [1:0]                size_q, size_d;
    logic                      sgn_q, sgn_d;
    logic [addr_width_p-1:0]   addr_q, addr_d;
    logic [data_width_p-1:0]   wdata_q, wdata_d;
    logic [tag_width_p-1:0]    tag_q, tag_d;
    logic [ptr_w_lp-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]       rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]       outstanding_q, outstanding_d;
    logic                      misalign_q, misalign_d;
    logic                      err_q, err_d;

    logic                      accept;
    logic                      illegal;
    logic                      issue;
    logic                      fifo_nonempty;
    logic                      pop;
    logic                      spurious;
    logic [data_width_p-1:0]   wdata_rep;
    logic [data_width_p-1:0]   lane_data;
    logic [data_width_p-1:0]   ext_mask;
    logic [data_width_p-1:0]   load_data;
    logic                      msb;
    entry_t                    fifo_mem [max_outstanding_p];
    entry_t                    head;
    entry_t                    push_entry;

    // Ready depends only on registered state, so mem_yumi_i never reaches req_ready_o.
    assign req_ready_o = !pending_q &&
        (({1'b0, outstanding_q} + (cnt_w_lp+1)'(pending_q)) < (cnt_w_lp+1)'(max_outstanding_p));
    assign accept = req_valid_i && req_ready_o;

    always_comb begin
        illegal = 1'b0;
        case (req_size_i)
            2'd1:    illegal = req_addr_i[0];
            2'd2:    illegal = |req_addr_i[1:0];
            2'd3:    illegal = (data_width_p != 64) || (|req_addr_i[2:0]);
            default: illegal = 1'b0;
        endcase
    end

    // Each byte lane takes the matching byte of the size-wide store value.
    for (genvar gi = 0; gi < nb_lp; gi++) begin : g_lane
        assign wdata_rep[gi*8 +: 8] =
            (req_size_i == 2'd0) ? req_wdata_i[7:0] :
            (req_size_i == 2'd1) ? req_wdata_i[(gi%2)*8 +: 8] :
            (req_size_i == 2'd2) ? req_wdata_i[(gi%4)*8 +: 8] :
                                   req_wdata_i[gi*8 +: 8];
    end

    assign issue         = pending_q && mem_yumi_i;
    assign fifo_nonempty = (outstanding_q != '0);
    assign head          = fifo_mem[rd_ptr_q];
    assign rsp_valid_o   = mem_rvalid_i && fifo_nonempty;
    assign pop           = rsp_valid_o && rsp_ready_i;
    assign spurious      = mem_rvalid_i && !fifo_nonempty;
    assign mem_yumi_o    = pop || spurious;

    assign push_entry = '{tag: tag_q, size: size_q, sgn: sgn_q, wen: wen_q,
                          off: addr_q[off_w_lp-1:0]};

    always_comb begin
        pending_d     = pending_q;
        wen_d         = wen_q;
        size_d        = size_q;
        sgn_d         = sgn_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        tag_d         = tag_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        misalign_d    = accept && illegal;
        err_d         = err_q || (accept && illegal) || spurious;

        if (issue) begin
            pending_d = 1'b0;
            wr_ptr_d  = (wr_ptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : wr_ptr_q + ptr_w_lp'(1);
        end
        if (accept && !illegal) begin
            pending_d = 1'b1;
            wen_d     = req_wen_i;
            size_d    = req_size_i;
            sgn_d     = req_signed_i;
            addr_d    = req_addr_i;
            wdata_d   = wdata_rep;
            tag_d     = req_tag_i;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : rd_ptr_q + ptr_w_lp'(1);
        end
        if (issue && !pop) begin
            outstanding_d = outstanding_q + cnt_w_lp'(1);
        end else if (pop && !issue) begin
            outstanding_d = outstanding_q - cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            pending_q     <= 1'b0;
            wen_q         <= 1'b0;
            size_q        <= '0;
            sgn_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            misalign_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            wen_q         <= wen_d;
            size_q        <= size_d;
            sgn_q         <= sgn_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            tag_q         <= tag_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            misalign_q    <= misalign_d;
            err_q         <= err_d;
        end
    end

    // Entry storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        lane_data = mem_rdata_i >> {head.off, 3'b000};
        case (head.size)
            2'd0: begin
                ext_mask = data_width_p'(8'hFF);
                msb      = lane_data[7];
            end
            2'd1: begin
                ext_mask = data_width_p'(16'hFFFF);
                msb      = lane_data[15];
            end
            2'd2: begin
                ext_mask = data_width_p'(32'hFFFF_FFFF);
                msb      = lane_data[31];
            end
            default: begin
                ext_mask = '1;
                msb      = lane_data[data_width_p-1];
            end
        endcase
        load_data = lane_data & ext_mask;
        if (head.sgn && msb) begin
            load_data = load_data | ~ext_mask;
        end
    end

    assign rsp_is_load_o = rsp_valid_o && !head.wen;
    assign rsp_tag_o     = rsp_valid_o ? head.tag : '0;
    assign rsp_data_o    = rsp_is_load_o ? load_data : '0;

    assign mem_valid_o   = pending_q;
    assign mem_wen_o     = wen_q;
    assign mem_size_o    = size_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign outstanding_o = outstanding_q;
    assign misalign_o    = misalign_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: directed scenarios plus random traffic, all checked against
// a queue-based model of pending, in-flight and completing accesses.
module tb_lsu_dmem_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int TW = 5;
    localparam int CW = $clog2(MO + 1);

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          req_valid_i, req_ready_o, req_wen_i, req_signed_i;
    logic [1:0]    req_size_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [TW-1:0] req_tag_i;
    logic          mem_valid_o, mem_wen_o, mem_yumi_i, mem_rvalid_i, mem_yumi_o;
    logic [1:0]    mem_size_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_is_load_o;
    logic [TW-1:0] rsp_tag_o;
    logic [DW-1:0] rsp_data_o;
    logic [CW-1:0] outstanding_o;
    logic          misalign_o, err_o;

    always #5 clk = ~clk;

    lsu_dmem_ctrl #(
        .addr_width_p(AW), .data_width_p(DW), .max_outstanding_p(MO), .tag_width_p(TW)
    ) dut (
        .clk(clk), .n_reset(n_reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
        .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_tag_i(req_tag_i),
        .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_size_o(mem_size_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_yumi_i(mem_yumi_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_yumi_o(mem_yumi_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_is_load_o(rsp_is_load_o),
        .rsp_tag_o(rsp_tag_o), .rsp_data_o(rsp_data_o), .outstanding_o(outstanding_o),
        .misalign_o(misalign_o), .err_o(err_o)
    );

    typedef struct {
        logic          wen;
        logic [1:0]    size;
        logic          sgn;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [4:0]    tag;
    } req_t;

    req_t req_q[$];
    req_t fly_q[$];
    logic err_m = 1'b0;
    logic mis_m = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic        obs_rsp_valid, obs_myumi, obs_load;
    logic [4:0]  obs_tag;
    logic [31:0] obs_data, obs_wdata;
    logic [1:0]  obs_size;
    logic [CW-1:0] obs_out;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [1:0] size, input logic [31:0] addr);
        return (size != 2'd3) && ((addr % (32'd1 << size)) == 32'd0);
    endfunction

    // Lane pick, truncate to the access size, then two's-complement extend with plain arithmetic.
    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input logic sgn);
        longint unsigned bits, v;
        bits = 64'd8 << size;
        v = (64'(rdata) >> ((addr % 32'd4) * 32'd8)) % (64'd1 << bits);
        if (sgn && v >= (64'd1 << (bits - 1))) v = v + (64'd1 << 32) - (64'd1 << bits);
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wdata, input logic [1:0] size);
        longint unsigned bits, piece, r;
        bits  = 64'd8 << size;
        piece = 64'(wdata) % (64'd1 << bits);
        r     = 0;
        for (int i = 0; i < 32; i += int'(bits)) r = r | (piece << i);
        return r[31:0];
    endfunction

    task automatic clear_in();
        req_valid_i = 0; req_wen_i = 0; req_size_i = 0; req_signed_i = 0;
        req_addr_i = 0; req_wdata_i = 0; req_tag_i = 0;
        mem_yumi_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; rsp_ready_i = 0;
    endtask

    task automatic do_reset();
        clear_in();
        n_reset = 1'b0;
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        req_q.delete();
        fly_q.delete();
        err_m = 1'b0;
        mis_m = 1'b0;
    endtask

    // One clock: check every output against the model, then advance the model across the edge.
    task automatic cyc();
        bit   acc, ill, iss, pop, spur, rdy, nxt_mis, nxt_err;
        req_t e, n;
        #1;
        rdy = (req_q.size() == 0) && (fly_q.size() < MO);
        check("ready", 64'(req_ready_o), 64'(rdy));
        check("outstanding", 64'(outstanding_o), 64'(fly_q.size()));
        check("err", 64'(err_o), 64'(err_m));
        check("misalign", 64'(misalign_o), 64'(mis_m));
        check("mem_valid", 64'(mem_valid_o), 64'(req_q.size() != 0));
        if (req_q.size() != 0) begin
            e = req_q[0];
            check("mem_addr", 64'(mem_addr_o), 64'(e.addr));
            check("mem_wen", 64'(mem_wen_o), 64'(e.wen));
            check("mem_size", 64'(mem_size_o), 64'(e.size));
            check("mem_wdata", 64'(mem_wdata_o), 64'(exp_wdata(e.wdata, e.size)));
        end
        spur = mem_rvalid_i && (fly_q.size() == 0);
        check("mem_yumi_o", 64'(mem_yumi_o), 64'(mem_rvalid_i && ((fly_q.size() == 0) || rsp_ready_i)));
        check("rsp_valid", 64'(rsp_valid_o), 64'(mem_rvalid_i && (fly_q.size() != 0)));
        obs_rsp_valid = rsp_valid_o;
        obs_myumi     = mem_yumi_o;
        pop = mem_rvalid_i && (fly_q.size() != 0) && rsp_ready_i;
        if (mem_rvalid_i && fly_q.size() != 0) begin
            e = fly_q[0];
            obs_tag  = rsp_tag_o;
            obs_load = rsp_is_load_o;
            obs_data = rsp_data_o;
            check("rsp_tag", 64'(rsp_tag_o), 64'(e.tag));
            check("rsp_is_load", 64'(rsp_is_load_o), 64'(!e.wen));
            check("rsp_data", 64'(rsp_data_o),
                  64'(e.wen ? 32'd0 : exp_load(mem_rdata_i, e.addr, e.size, e.sgn)));
        end
        acc = req_valid_i && rdy;
        ill = !legal(req_size_i, req_addr_i);
        iss = (req_q.size() != 0) && mem_yumi_i;
        nxt_mis = acc && ill;
        nxt_err = err_m || (acc && ill) || spur;
        if (pop) begin
            e = fly_q.pop_front();
            $display("rsp tag=%0d load=%0b addr=%08h data=%08h", e.tag, !e.wen, e.addr, rsp_data_o);
        end
        if (iss) fly_q.push_back(req_q.pop_front());
        if (acc && !ill) begin
            n.wen = req_wen_i; n.size = req_size_i; n.sgn = req_signed_i;
            n.addr = req_addr_i; n.wdata = req_wdata_i; n.tag = req_tag_i;
            req_q.push_back(n);
        end
        if (acc && ill) $display("req tag=%0d addr=%08h size=%0d rejected", req_tag_i, req_addr_i, req_size_i);
        if (spur) $display("spurious response drained");
        @(posedge clk);
        mis_m = nxt_mis;
        err_m = nxt_err;
        #1;
    endtask

    task automatic one_access(input logic wen, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] tag, input logic [31:0] rdata);
        clear_in();
        req_valid_i = 1; req_wen_i = wen; req_size_i = size; req_signed_i = sgn;
        req_addr_i = addr; req_wdata_i = wdata; req_tag_i = tag;
        cyc();
        clear_in();
        obs_wdata = mem_wdata_o;
        obs_size  = mem_size_o;
        mem_yumi_i = 1;
        cyc();
        mem_yumi_i = 0;
        obs_out = outstanding_o;
        cyc();
        mem_rvalid_i = 1; mem_rdata_i = rdata; rsp_ready_i = 1;
        cyc();
        clear_in();
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        clear_in();
        do_reset();
        cyc();

        one_access(0, 2'd2, 0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF);
        check("wload_out1", 64'(obs_out), 64'd1);
        check("wload_data", 64'(obs_data), 64'hDEADBEEF);
        check("wload_isld", 64'(obs_load), 64'd1);
        check("wload_tag", 64'(obs_tag), 64'd5);
        check("wload_out0", 64'(outstanding_o), 64'd0);

        one_access(0, 2'd0, 1, 32'h103, 32'h0, 5'd7, 32'h80FF_0011);
        check("lb_signed", 64'(obs_data), 64'hFFFF_FF80);
        one_access(0, 2'd0, 0, 32'h103, 32'h0, 5'd8, 32'h80FF_0011);
        check("lb_unsigned", 64'(obs_data), 64'h0000_0080);

        one_access(1, 2'd1, 0, 32'h102, 32'h1234, 5'd9, 32'hCAFE_F00D);
        check("sh_wdata", 64'(obs_wdata), 64'h1234_1234);
        check("sh_size", 64'(obs_size), 64'd1);
        check("sh_isld", 64'(obs_load), 64'd0);
        check("sh_data", 64'(obs_data), 64'd0);

        for (int i = 0; i < 4; i++) begin
            clear_in();
            req_valid_i = 1; req_size_i = 2'd2; req_addr_i = 32'h200 + 32'(4 * i);
            req_tag_i = 5'(10 + i); mem_yumi_i = 1;
            cyc();
            if (i == 3) check("burst_rdy_low", 64'(req_ready_o), 64'd0);
            req_valid_i = 0;
            cyc();
        end
        check("burst_out4", 64'(outstanding_o), 64'd4);
        req_valid_i = 1; req_size_i = 2'd2; req_addr_i = 32'h300; req_tag_i = 5'd20;
        cyc();
        cyc();
        clear_in();
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = 1; rsp_ready_i = 1; mem_rdata_i = $urandom();
            cyc();
            check("burst_tag", 64'(obs_tag), 64'(10 + i));
            if (i == 0) check("burst_rdy_up", 64'(req_ready_o), 64'd1);
        end
        clear_in();

        req_valid_i = 1; req_size_i = 2'd2; req_addr_i = 32'h101; req_tag_i = 5'd3;
        cyc();
        clear_in();
        check("mis_pulse", 64'(misalign_o), 64'd1);
        check("mis_err", 64'(err_o), 64'd1);
        check("mis_memvalid", 64'(mem_valid_o), 64'd0);
        cyc();
        check("mis_pulse_end", 64'(misalign_o), 64'd0);
        cyc();

        do_reset();
        cyc();
        mem_rvalid_i = 1; mem_rdata_i = 32'h1111_2222;
        cyc();
        clear_in();
        check("spur_yumi", 64'(obs_myumi), 64'd1);
        check("spur_rspv", 64'(obs_rsp_valid), 64'd0);
        check("spur_err", 64'(err_o), 64'd1);

        do_reset();
        for (int i = 0; i < 2; i++) begin
            req_valid_i = 1; req_size_i = 2'd2; req_addr_i = 32'h400 + 32'(4 * i); req_tag_i = 5'(i);
            cyc();
            req_valid_i = 0; mem_yumi_i = 1;
            cyc();
            mem_yumi_i = 0;
        end
        check("mid_out2", 64'(outstanding_o), 64'd2);
        do_reset();
        check("rst_out0", 64'(outstanding_o), 64'd0);
        check("rst_err0", 64'(err_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        mem_rvalid_i = 1; mem_rdata_i = 32'h5;
        cyc();
        clear_in();
        check("late_err", 64'(err_o), 64'd1);

        do_reset();
        for (int c = 0; c < 2000; c++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom();
            if ($urandom_range(0, 99) < 85) a = a & ~((32'd1 << sz) - 32'd1);
            req_valid_i  = ($urandom_range(0, 1) == 1);
            req_wen_i    = ($urandom_range(0, 1) == 1);
            req_size_i   = sz;
            req_signed_i = ($urandom_range(0, 1) == 1);
            req_addr_i   = a;
            req_wdata_i  = $urandom();
            req_tag_i    = 5'($urandom_range(0, 31));
            mem_yumi_i   = ($urandom_range(0, 1) == 1);
            mem_rvalid_i = (fly_q.size() != 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom();
            rsp_ready_i  = ($urandom_range(0, 9) < 7);
            cyc();
        end
        clear_in();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
